// File: rtl/bk_pipe_alu.sv
// ============================================================================
// Module      : bk_pipe_alu
// Description : Brent-Kung prefix ALU (ADD/SUB/ACC/LOAD) with accumulator and
//               a STAGES-deep elastic valid/ready output pipeline.
//               Define BK_SATURATE_EN to clamp results on carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bk_pipe_alu #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             ovf,
    output logic             zero
);

    localparam int         c_LOG  = $clog2(WIDTH);
    localparam int         c_DW   = WIDTH + 3;
    localparam logic [1:0] c_ADD  = 2'b00;
    localparam logic [1:0] c_SUB  = 2'b01;
    localparam logic [1:0] c_ACC  = 2'b10;
    localparam logic [1:0] c_LOAD = 2'b11;

    logic [WIDTH-1:0] r_acc;
    logic [STAGES-1:0] r_valid;
    logic [c_DW-1:0]  r_data [STAGES];

    logic [WIDTH-1:0] w_x, w_y, w_pbit, w_g, w_p, w_sum, w_raw, w_lo;
    logic             w_ci, w_cout, w_flag;
    logic [c_DW-1:0]  w_new;
    logic [c_DW-1:0]  w_stage_in [STAGES];
    logic [STAGES:0]  w_room, w_fire;
    logic             w_in_ready;

    always_comb begin
        w_x  = a;
        w_y  = '0;
        w_ci = 1'b0;
        case (mode)
            c_ADD: begin w_y = b;  w_ci = cin; end
            c_SUB: begin w_y = ~b; w_ci = 1'b1; end
            c_ACC: begin w_x = r_acc; w_y = a; w_ci = cin; end
            default: ;
        endcase
    end

    assign w_pbit = w_x ^ w_y;

    // Prefix tree: carry-in folded into bit 0 so every w_g[i] ends as carry out of bit i.
    always_comb begin
        w_g    = w_x & w_y;
        w_p    = w_pbit;
        w_g[0] = w_g[0] | (w_p[0] & w_ci);
        for (int l = 0; l < c_LOG; l++) begin
            for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                w_p[i] = w_p[i] & w_p[i - (1 << l)];
            end
        end
        for (int l = c_LOG - 2; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                w_p[i] = w_p[i] & w_p[i - (1 << l)];
            end
        end
    end

    assign w_sum  = w_pbit ^ {w_g[WIDTH-2:0], w_ci};
    assign w_cout = w_g[WIDTH-1];

    always_comb begin
        w_raw  = w_sum;
        w_flag = 1'b0;
        case (mode)
            c_ADD, c_ACC: w_flag = w_cout;
            c_SUB:        w_flag = ~w_cout;
            default:      w_raw  = a;
        endcase
    end

`ifdef BK_SATURATE_EN
    assign w_lo = w_flag ? ((mode == c_SUB) ? '0 : '1) : w_raw;
`else
    assign w_lo = w_raw;
`endif

    assign w_new = {w_flag, w_lo, w_flag, (w_lo == '0)};

    // w_room[i]: stage i can take data this cycle; w_fire[i]: data moves into stage i.
    always_comb begin
        w_room         = '0;
        w_fire         = '0;
        w_room[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_fire[i+1] = r_valid[i] & w_room[i+1];
            w_room[i]   = ~r_valid[i] | w_fire[i+1];
        end
        w_in_ready = ~rst & w_room[0];
        w_fire[0]  = in_valid & w_in_ready;
    end

    always_comb begin
        w_stage_in[0] = w_new;
        for (int i = 1; i < STAGES; i++) begin
            w_stage_in[i] = r_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_acc   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_fire[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= w_stage_in[i];
                end else if (w_fire[i+1]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_fire[0]) begin
                if (mode == c_ACC) begin
                    r_acc <= w_lo;
                end else if (mode == c_LOAD) begin
                    r_acc <= a;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid[STAGES-1];
    assign result    = r_data[STAGES-1][c_DW-1:2];
    assign ovf       = r_data[STAGES-1][1];
    assign zero      = r_data[STAGES-1][0];

endmodule

`default_nettype wire
